// File: rtl/fetch_pred_pkg.sv
// Shared definitions for the fetch predictor: counter encodings, link
// register numbers and the checkpoint width helper.
package fetch_pred_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  localparam logic [1:0] CNT_RESET = CNT_WNT;

  // Architectural link registers recognised by decode for call/return hints.
  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  // Checkpoint is {ghr, ras_top, ras_count}; count needs one extra bit to
  // represent a full stack. Pass ghr_w = 0 when history is compiled out.
  function automatic int ckpt_w(input int ghr_w, input int ras_depth);
    return ghr_w + 2 * $clog2(ras_depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_predictor_ras.sv
// Circular return address stack. top points at the most recent entry;
// count saturates at RAS_DEPTH so a push on a full stack silently
// overwrites the oldest entry. restore rewinds top/count only.
module ras_stack #(
  parameter  int XLEN      = 32,
  parameter  int RAS_DEPTH = 4,
  localparam int PW        = $clog2(RAS_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            restore,
  input  logic [PW-1:0]   restore_top,
  input  logic [CW-1:0]   restore_count,
  input  logic [XLEN-1:0] link,
  output logic [PW-1:0]   top,
  output logic [CW-1:0]   count,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic            empty;
  logic            full;

  assign empty  = (count == '0);
  assign full   = (count == CW'(RAS_DEPTH));
  assign target = empty ? '0 : mem[top];

  // Push/pop/restore; a simultaneous pop+push on a non-empty stack
  // collapses into an in-place replace of the top entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
      top   <= '0;
      count <= '0;
    end else if (restore) begin
      top   <= restore_top;
      count <= restore_count;
    end else if (push) begin
      if (pop && !empty) begin
        mem[top] <= link;
      end else begin
        mem[top + PW'(1)] <= link;
        top               <= top + PW'(1);
        if (!full) count  <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      top   <= top - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_predictor.sv
// IF-stage direction + return address predictor.
// Build option FETCH_PRED_GSHARE_EN: when defined the counter index is
// gshare (pc ^ global history) and the checkpoint carries the history;
// otherwise the index is pc-only and the checkpoint holds only RAS state.
module fetch_predictor
  import fetch_pred_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int BHT_DEPTH = 64,
  parameter  int GHR_WIDTH = 6,
  parameter  int RAS_DEPTH = 4,
`ifdef FETCH_PRED_GSHARE_EN
  localparam int GW        = GHR_WIDTH,
`else
  localparam int GW        = 0,
`endif
  localparam int CKW       = ckpt_w(GW, RAS_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PL_stall,
  input  logic            PL_flush,
  input  logic            q_valid,
  input  logic [XLEN-1:0] q_pc,
  input  logic            q_btype,
  input  logic            q_call,
  input  logic            q_ret,
  input  logic [XLEN-1:0] q_link,
  output logic            pred_taken,
  output logic            ras_valid,
  output logic [XLEN-1:0] ras_target,
  output logic [CKW-1:0]  pred_ckpt,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [CKW-1:0]  upd_ckpt
);

  localparam int IDXW = $clog2(BHT_DEPTH);
  localparam int PW   = $clog2(RAS_DEPTH);
  localparam int CW   = PW + 1;

  if (GHR_WIDTH > IDXW) begin : g_bad_ghr
    $error("GHR_WIDTH must not exceed log2(BHT_DEPTH)");
  end

  logic [1:0]      cnt [BHT_DEPTH];
  logic [IDXW-1:0] q_idx;
  logic [IDXW-1:0] u_idx;
  logic [PW-1:0]   ras_top;
  logic [CW-1:0]   ras_count;
  logic            spec_ok;

  // Speculative state only moves for a live, unstalled, unflushed query.
  assign spec_ok = q_valid & ~PL_stall & ~PL_flush;

`ifdef FETCH_PRED_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr;
  logic [GHR_WIDTH-1:0] u_ghr;

  assign u_ghr     = upd_ckpt[CKW-1 -: GHR_WIDTH];
  assign q_idx     = q_pc[IDXW+1:2] ^ IDXW'(ghr);
  assign u_idx     = upd_pc[IDXW+1:2] ^ IDXW'(u_ghr);
  assign pred_ckpt = {ghr, ras_top, ras_count};

  // Global history: flush rebuilds from the branch's checkpoint (plus its
  // resolved outcome), otherwise shift in each predicted B-type direction.
  always_ff @(posedge clk) begin
    if (rst)
      ghr <= '0;
    else if (PL_flush)
      ghr <= upd_valid ? {u_ghr[GHR_WIDTH-2:0], upd_taken} : u_ghr;
    else if (q_valid && q_btype && !PL_stall)
      ghr <= {ghr[GHR_WIDTH-2:0], pred_taken};
  end
`else
  assign q_idx     = q_pc[IDXW+1:2];
  assign u_idx     = upd_pc[IDXW+1:2];
  assign pred_ckpt = {ras_top, ras_count};
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{q_pc[1:0], q_pc[XLEN-1:IDXW+2],
                            upd_pc[1:0], upd_pc[XLEN-1:IDXW+2]};

  // Read is a plain combinational lookup of the registered table, so a
  // same-cycle update to the same index is seen only from the next cycle.
  assign pred_taken = q_btype & cnt[q_idx][1];
  assign ras_valid  = q_ret & (ras_count != '0);

  // Saturating counter training; resolved updates land even while stalled
  // or flushing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) cnt[i] <= CNT_RESET;
    end else if (upd_valid) begin
      if (upd_taken && cnt[u_idx] != CNT_ST)
        cnt[u_idx] <= cnt[u_idx] + 2'd1;
      else if (!upd_taken && cnt[u_idx] != CNT_SNT)
        cnt[u_idx] <= cnt[u_idx] - 2'd1;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk           (clk),
    .rst           (rst),
    .push          (spec_ok & q_call),
    .pop           (spec_ok & q_ret),
    .restore       (PL_flush),
    .restore_top   (upd_ckpt[CW+PW-1:CW]),
    .restore_count (upd_ckpt[CW-1:0]),
    .link          (q_link),
    .top           (ras_top),
    .count         (ras_count),
    .target        (ras_target)
  );

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed bench for fetch_predictor with a scoreboard queue: the driver
// pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_fetch_predictor;
  import fetch_pred_pkg::*;

  localparam int XLEN = 32, BHT_DEPTH = 64, GHR_WIDTH = 6, RAS_DEPTH = 4;
`ifdef FETCH_PRED_GSHARE_EN
  localparam int  CKW = ckpt_w(GHR_WIDTH, RAS_DEPTH);
  localparam logic GS = 1'b1;
`else
  localparam int  CKW = ckpt_w(0, RAS_DEPTH);
  localparam logic GS = 1'b0;
`endif

  logic            clk = 0, rst = 1;
  logic            PL_stall, PL_flush, q_valid, q_btype, q_call, q_ret;
  logic [XLEN-1:0] q_pc, q_link, upd_pc, ras_target;
  logic            pred_taken, ras_valid, upd_valid, upd_taken;
  logic [CKW-1:0]  pred_ckpt, upd_ckpt;

  fetch_predictor #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .GHR_WIDTH(GHR_WIDTH),
                    .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .PL_stall(PL_stall), .PL_flush(PL_flush),
    .q_valid(q_valid), .q_pc(q_pc), .q_btype(q_btype), .q_call(q_call),
    .q_ret(q_ret), .q_link(q_link), .pred_taken(pred_taken),
    .ras_valid(ras_valid), .ras_target(ras_target), .pred_ckpt(pred_ckpt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_ckpt(upd_ckpt));

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            pt;
    logic            rv;
    logic [31:0]     rt;
    logic [CKW-1:0]  ck;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0, passed = 0;
  logic sample = 0, done = 0, final_seen = 0;

  // Checkpoint {ghr, top, count}; the ghr bits fall away when history is off.
  function automatic logic [CKW-1:0] mk_ck(input logic [5:0] g, input logic [1:0] t,
                                           input logic [2:0] c);
    return CKW'({g, t, c});
  endfunction

  task automatic cmp(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s.%s got %h want %h", n, f, act, want);
  endtask

  // Monitor: pops one expectation per sampled cycle.
  always @(negedge clk) begin
    if (sample) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_underflow got empty want entry");
      end else begin
        m_e = sb.pop_front();
        cmp(m_e.name, "pred_taken", 32'(pred_taken), 32'(m_e.pt));
        cmp(m_e.name, "ras_valid",  32'(ras_valid),  32'(m_e.rv));
        cmp(m_e.name, "ras_target", ras_target,      m_e.rt);
        cmp(m_e.name, "pred_ckpt",  32'(pred_ckpt),  32'(m_e.ck));
      end
    end
    if (done && !final_seen) begin
      final_seen <= 1'b1;
      cmp("drain", "queue_left", sb.size(), 0);
    end
  end

  task automatic idle();
    PL_stall = 0; PL_flush = 0; q_valid = 0; q_btype = 0; q_call = 0; q_ret = 0;
    q_pc = 0; q_link = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_ckpt = '0;
  endtask

  task automatic chk(input string n, input logic pt, input logic rv,
                     input logic [31:0] rt, input logic [CKW-1:0] ck);
    exp_t e;
    e.name = n; e.pt = pt; e.rv = rv; e.rt = rt; e.ck = ck;
    sb.push_back(e);
    sample = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    sample = 0;
    idle();
  endtask

  task automatic push_link(input logic [31:0] l);
    q_valid = 1; q_call = 1; q_link = l;
    tick();
  endtask

  int            bht_upd[10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, -1};
  logic          bht_exp[10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
  logic [31:0]   pops[5]     = '{32'hE00, 32'hD00, 32'hC00, 32'hB00, 32'h0};
  logic [1:0]    pop_top[5]  = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
  logic [2:0]    pop_cnt[5]  = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    q_btype = 1; q_pc = 32'h40;
    chk("reset", 0, 0, 0, '0);
    tick();
    rst = 0;

    // Counter training at pc 0x40 (history kept at 0: q_valid low).
    for (int i = 0; i < 10; i++) begin
      q_btype = 1; q_pc = 32'h40;
      if (bht_upd[i] >= 0) begin
        upd_valid = 1; upd_pc = 32'h40; upd_taken = bht_upd[i][0];
      end
      chk($sformatf("bht_%0d", i), bht_exp[i], 0, 0, '0);
      tick();
    end
    q_btype = 0; q_pc = 32'h40;
    chk("bht_not_btype", 0, 0, 0, '0);
    tick();
    q_btype = 1; q_pc = 32'h44;
    chk("bht_other_idx", 0, 0, 0, '0);
    tick();

    // Basic push/pop.
    push_link(32'h104);
    q_valid = 1; q_call = 1; q_link = 32'h208;
    chk("ras_push1", 0, 0, 32'h104, mk_ck(0, 1, 1));
    tick();
    q_valid = 1; q_ret = 1;
    chk("ras_pop_208", 0, 1, 32'h208, mk_ck(0, 2, 2));
    tick();
    q_valid = 1; q_ret = 1;
    chk("ras_pop_104", 0, 1, 32'h104, mk_ck(0, 1, 1));
    tick();
    q_valid = 1; q_ret = 1;
    chk("ras_pop_empty", 0, 0, 0, mk_ck(0, 0, 0));
    tick();

    // Overflow: five pushes into four entries drops the oldest.
    push_link(32'hA00); push_link(32'hB00); push_link(32'hC00);
    push_link(32'hD00); push_link(32'hE00);
    for (int i = 0; i < 5; i++) begin
      q_valid = 1; q_ret = 1;
      chk($sformatf("ras_ovf_pop%0d", i), 0, (i < 4), pops[i],
          mk_ck(0, pop_top[i], pop_cnt[i]));
      tick();
    end

    // Call+ret replaces top in place.
    push_link(32'h300);
    q_valid = 1; q_call = 1; q_ret = 1; q_link = 32'h500;
    chk("ras_callret", 0, 1, 32'h300, mk_ck(0, 2, 1));
    tick();
    chk("ras_replaced", 0, 0, 32'h500, mk_ck(0, 2, 1));
    tick();

    // Three speculative B-type queries at 0x40 (counter there is weak-T).
    for (int i = 0; i < 3; i++) begin
      q_valid = 1; q_btype = 1; q_pc = 32'h40;
      chk($sformatf("ghr_shift%0d", i), (i == 0) ? 1'b1 : !GS, 0, 32'h500,
          mk_ck(6'(i), 2, 1));
      tick();
    end

    // Flush: query ignored, history rebuilt, RAS pointers restored.
    PL_flush = 1; q_valid = 1; q_call = 1; q_link = 32'h999;
    upd_valid = 1; upd_taken = 1; upd_pc = 32'h80; upd_ckpt = mk_ck(6'b000101, 3, 2);
    chk("flush_cycle", 0, 0, 32'h500, mk_ck(6'd4, 2, 1));
    tick();
    chk("flush_restore", 0, 0, 32'hC00, mk_ck(6'b001011, 3, 2));
    tick();

    // Stall freezes history and RAS; counter update still lands.
    for (int i = 0; i < 3; i++) begin
      PL_stall = 1; q_valid = 1; q_call = 1; q_btype = 1; q_pc = 32'h44;
      q_link = 32'h777;
      if (i == 0) begin
        upd_valid = 1; upd_taken = 1; upd_pc = 32'h44; upd_ckpt = mk_ck(6'b001011, 0, 0);
      end
      chk($sformatf("stall%0d", i), (i != 0), 0, 32'hC00, mk_ck(6'b001011, 3, 2));
      tick();
    end
    q_btype = 1; q_pc = 32'h44;
    chk("stall_after", 1, 0, 32'hC00, mk_ck(6'b001011, 3, 2));
    tick();

    // Reset mid-run wins over everything else.
    rst = 1; q_valid = 1; q_call = 1; q_link = 32'h123; q_btype = 1;
    upd_valid = 1; upd_taken = 1; upd_pc = 32'h44;
    tick();
    rst = 0;
    q_btype = 1; q_pc = 32'h44; q_ret = 1;
    chk("reset_mid", 0, 0, 0, '0);
    tick();

    done = 1;
    for (int i = 0; i < 5 && !final_seen; i++) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
